// File: rtl/raw_frame_sequencer.sv
// raw_frame_sequencer
// Takes raw sensor timing (FVAL/LVAL/data) and drives the demosaic stage.
// It locks onto frame boundaries and produces a per-pixel X/Y count. The
// parity of that count selects the Bayer phase. Pixel-valid is gated to the
// active window. Frame events and line-length errors are reported.
//
// Ports:
//   iCLK, iRST_n        pixel clock, synchronous active-low reset
//   iStart              capture enable (level)
//   iFval, iLval, iData raw sensor timing and pixel
//   oData, oDval        pixel and pixel-valid to demosaic (2-cycle latency)
//   oX_Cont, oY_Cont    column/row of the current pixel, held while oDval=0
//   oFrame_Cont         completed-frame count (wraps)
//   oSOF, oEOF          one-cycle frame start/end pulses
//   oLineErr            sticky short/long line flag, cleared at SOF
//   oBusy               high while the sequencer is not idle
module raw_frame_sequencer #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iStart,
    input  logic              iFval,
    input  logic              iLval,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oData,
    output logic              oDval,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [31:0]       oFrame_Cont,
    output logic              oSOF,
    output logic              oEOF,
    output logic              oLineErr,
    output logic              oBusy
);

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_FRAME = 2'd2,
        ACTIVE     = 2'd3
    } state_t;

    state_t state;

    // s1: first register of the sensor inputs; s2: previous s1 for edges.
    // oData is itself the s2 data stage, which gives the 2-cycle latency.
    logic              s1Fval;
    logic              s1Lval;
    logic [DATA_W-1:0] s1Data;
    logic              s2Fval;
    logic              s2Lval;

    // Next pixel column and current row inside the frame.
    logic [CNT_W-1:0]  xCnt;
    logic [CNT_W-1:0]  yCnt;

    logic fvalRise;
    logic fvalFall;
    logic pixQual;
    logic lineEnd;

    always_comb begin
        fvalRise = s1Fval & ~s2Fval;
        fvalFall = ~s1Fval & s2Fval;
        pixQual  = s1Fval & s1Lval;
        // A line ends when the previous cycle was a qualified pixel and the
        // current one is not. This also covers Fval dropping under Lval.
        lineEnd  = s2Fval & s2Lval & ~pixQual;
    end

    // Input pipeline, sequencer FSM, pixel counting and registered outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state       <= IDLE;
            s1Fval      <= 1'b0;
            s1Lval      <= 1'b0;
            s1Data      <= '0;
            s2Fval      <= 1'b0;
            s2Lval      <= 1'b0;
            xCnt        <= '0;
            yCnt        <= '0;
            oData       <= '0;
            oDval       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oSOF        <= 1'b0;
            oEOF        <= 1'b0;
            oLineErr    <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            s1Fval <= iFval;
            s1Lval <= iLval;
            s1Data <= iData;
            s2Fval <= s1Fval;
            s2Lval <= s1Lval;
            oData  <= s1Data;

            oDval  <= 1'b0;
            oSOF   <= 1'b0;
            oEOF   <= 1'b0;

            case (state)
                IDLE: begin
                    if (iStart) begin
                        state <= ARM;
                        oBusy <= 1'b1;
                    end else begin
                        oBusy <= 1'b0;
                    end
                end

                // Never start mid-frame: wait for Fval low first.
                ARM: begin
                    oBusy <= 1'b1;
                    if (!s1Fval) begin
                        state <= WAIT_FRAME;
                    end
                end

                WAIT_FRAME: begin
                    if (!iStart) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        oBusy <= 1'b1;
                        if (fvalRise) begin
                            state    <= ACTIVE;
                            oSOF     <= 1'b1;
                            oLineErr <= 1'b0;
                            yCnt     <= '0;
                            // A pixel arriving with the Fval rise is X=0, Y=0.
                            if (s1Lval) begin
                                oDval   <= 1'b1;
                                oX_Cont <= '0;
                                oY_Cont <= '0;
                                xCnt    <= CNT_W'(1);
                            end else begin
                                xCnt    <= '0;
                            end
                        end
                    end
                end

                ACTIVE: begin
                    oBusy <= 1'b1;
                    if (lineEnd) begin
                        if ((xCnt != H_MAX) && (yCnt < V_MAX)) begin
                            oLineErr <= 1'b1;
                        end
                        xCnt <= '0;
                        if (yCnt < V_MAX) begin
                            yCnt <= yCnt + CNT_W'(1);
                        end
                    end else if (pixQual && (yCnt < V_MAX)) begin
                        if (xCnt < H_MAX) begin
                            oDval   <= 1'b1;
                            oX_Cont <= xCnt;
                            oY_Cont <= yCnt;
                            xCnt    <= xCnt + CNT_W'(1);
                        end else begin
                            // Long line: drop excess pixels, X stays saturated.
                            oLineErr <= 1'b1;
                        end
                    end

                    // iStart is only consulted at frame end, so a frame in
                    // progress always completes.
                    if (fvalFall) begin
                        oEOF        <= 1'b1;
                        oFrame_Cont <= oFrame_Cont + 32'd1;
                        if (iStart) begin
                            state <= WAIT_FRAME;
                        end else begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raw_frame_sequencer.sv
// Self-checking bench for raw_frame_sequencer with a 4x3 active window.
module tb_raw_frame_sequencer;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned H_ACT  = 4;
    localparam int unsigned V_ACT  = 3;

    logic              iCLK;
    logic              iRST_n;
    logic              iStart;
    logic              iFval;
    logic              iLval;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;
    logic              oDval;
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic [31:0]       oFrame_Cont;
    logic              oSOF;
    logic              oEOF;
    logic              oLineErr;
    logic              oBusy;

    raw_frame_sequencer #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .H_ACTIVE(H_ACT),
        .V_ACTIVE(V_ACT)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iStart     (iStart),
        .iFval      (iFval),
        .iLval      (iLval),
        .iData      (iData),
        .oData      (oData),
        .oDval      (oDval),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oSOF       (oSOF),
        .oEOF       (oEOF),
        .oLineErr   (oLineErr),
        .oBusy      (oBusy)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  x;
        logic [CNT_W-1:0]  y;
    } pix_t;

    typedef struct {
        int   nLines;
        int   normLen;
        int   specIdx;
        int   specLen;
        int   expDval;
        logic expErr;
    } vec_t;

    pix_t gotQ[$];
    pix_t expQ[$];
    int   sofCnt;
    int   eofCnt;
    int   nChecks;
    int   nFail;
    int   expFrames;
    vec_t vecs[5];

    // Output monitor sampled on the falling edge.
    always @(negedge iCLK) begin
        if (oDval) gotQ.push_back('{d: oData, x: oX_Cont, y: oY_Cont});
        if (oSOF) sofCnt++;
        if (oEOF) eofCnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clearMon();
        gotQ.delete();
        expQ.delete();
        sofCnt = 0;
        eofCnt = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " oData"}, 32'(oData), 32'd0);
        check({tag, " oDval"}, 32'(oDval), 32'd0);
        check({tag, " oX_Cont"}, 32'(oX_Cont), 32'd0);
        check({tag, " oY_Cont"}, 32'(oY_Cont), 32'd0);
        check({tag, " oFrame_Cont"}, oFrame_Cont, 32'd0);
        check({tag, " oSOF"}, 32'(oSOF), 32'd0);
        check({tag, " oEOF"}, 32'(oEOF), 32'd0);
        check({tag, " oLineErr"}, 32'(oLineErr), 32'd0);
        check({tag, " oBusy"}, 32'(oBusy), 32'd0);
    endtask

    // One frame: 2 blank cycles, lines separated by 2 blank cycles, 4-cycle tail.
    task automatic runFrame(input int nLines, input int normLen, input int specIdx,
                            input int specLen, input int dropLine, input bit expectPix);
        int len;
        int dv;
        dv = 1;
        iFval = 1'b1;
        iLval = 1'b0;
        tick(2);
        for (int l = 0; l < nLines; l++) begin
            len = (l == specIdx) ? specLen : normLen;
            for (int p = 0; p < len; p++) begin
                if (l == dropLine && p == 1) iStart = 1'b0;
                iLval = 1'b1;
                iData = DATA_W'(dv);
                if (expectPix && p < int'(H_ACT) && l < int'(V_ACT))
                    expQ.push_back('{d: DATA_W'(dv), x: CNT_W'(p), y: CNT_W'(l)});
                dv++;
                tick(1);
            end
            iLval = 1'b0;
            tick(2);
        end
        iFval = 1'b0;
        tick(4);
    endtask

    task automatic compareFrame(input string tag, input int expDval, input logic expErr,
                                input int expSof, input int expEof, input logic expBusy);
        int n;
        check({tag, " dval count"}, 32'(gotQ.size()), 32'(expDval));
        check({tag, " expected list size"}, 32'(expQ.size()), 32'(expDval));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s pix%0d data", tag, i), 32'(gotQ[i].d), 32'(expQ[i].d));
            check($sformatf("%s pix%0d X", tag, i), 32'(gotQ[i].x), 32'(expQ[i].x));
            check($sformatf("%s pix%0d Y", tag, i), 32'(gotQ[i].y), 32'(expQ[i].y));
        end
        check({tag, " oLineErr"}, 32'(oLineErr), 32'(expErr));
        check({tag, " SOF pulses"}, 32'(sofCnt), 32'(expSof));
        check({tag, " EOF pulses"}, 32'(eofCnt), 32'(expEof));
        check({tag, " oFrame_Cont"}, oFrame_Cont, 32'(expFrames));
        check({tag, " oBusy"}, 32'(oBusy), 32'(expBusy));
    endtask

    initial begin
        nChecks   = 0;
        nFail     = 0;
        expFrames = 0;
        sofCnt    = 0;
        eofCnt    = 0;

        // nLines, normLen, specIdx, specLen, expDval, expErr
        vecs[0] = '{3, 4, -1, 0, 12, 1'b0};  // nominal 3x4
        vecs[1] = '{3, 4,  1, 3, 11, 1'b1};  // line 1 short (3 px)
        vecs[2] = '{3, 4,  0, 6, 12, 1'b1};  // line 0 long (6 px)
        vecs[3] = '{5, 4, -1, 0, 12, 1'b0};  // 5 lines, extra lines dropped
        vecs[4] = '{3, 4, -1, 0, 12, 1'b0};  // nominal, error flag cleared at SOF

        iRST_n = 1'b0;
        iStart = 1'b0;
        iFval  = 1'b0;
        iLval  = 1'b0;
        iData  = '0;
        tick(3);
        checkAllZero("reset");
        iRST_n = 1'b1;
        tick(2);

        // iStart raised while a frame is already in progress: nothing captured.
        clearMon();
        iFval = 1'b1;
        tick(3);
        iStart = 1'b1;
        tick(2);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                iLval = 1'b1;
                iData = DATA_W'(100 + p);
                tick(1);
            end
            iLval = 1'b0;
            tick(2);
        end
        iFval = 1'b0;
        tick(4);
        compareFrame("midstart", 0, 1'b0, 0, 0, 1'b1);

        // Table-driven frames with iStart held high.
        for (int i = 0; i < 5; i++) begin
            clearMon();
            runFrame(vecs[i].nLines, vecs[i].normLen, vecs[i].specIdx, vecs[i].specLen, -1, 1'b1);
            expFrames++;
            compareFrame($sformatf("vec%0d", i), vecs[i].expDval, vecs[i].expErr, 1, 1, 1'b1);
        end

        // Fval and Lval rise together; also checks SOF and data latency.
        clearMon();
        for (int p = 0; p < 4; p++) begin
            iFval = 1'b1;
            iLval = 1'b1;
            iData = DATA_W'(12'hA00 + p);
            expQ.push_back('{d: DATA_W'(12'hA00 + p), x: CNT_W'(p), y: CNT_W'(0)});
            tick(1);
            if (p == 0) begin
                check("simul SOF not early", 32'(oSOF), 32'd0);
                check("simul dval not early", 32'(oDval), 32'd0);
            end
            if (p == 1) begin
                check("simul SOF timing", 32'(oSOF), 32'd1);
                check("simul first dval", 32'(oDval), 32'd1);
                check("simul first X", 32'(oX_Cont), 32'd0);
                check("simul first Y", 32'(oY_Cont), 32'd0);
                check("simul first data", 32'(oData), 32'h0A00);
            end
        end
        iLval = 1'b0;
        tick(2);
        iFval = 1'b0;
        tick(4);
        expFrames++;
        compareFrame("simul", 4, 1'b0, 1, 1, 1'b1);

        // iStart dropped during line 0: frame completes, then idle.
        clearMon();
        runFrame(3, 4, -1, 0, 0, 1'b1);
        expFrames++;
        compareFrame("startdrop", 12, 1'b0, 1, 1, 1'b0);

        // Frame while idle: ignored.
        clearMon();
        runFrame(3, 4, -1, 0, -1, 1'b0);
        compareFrame("idleframe", 0, 1'b0, 0, 0, 1'b0);

        // One-cycle reset mid-line.
        iStart = 1'b1;
        tick(3);
        iFval = 1'b1;
        tick(2);
        for (int p = 0; p < 2; p++) begin
            iLval = 1'b1;
            iData = DATA_W'(200 + p);
            tick(1);
        end
        iRST_n = 1'b0;
        tick(1);
        checkAllZero("midreset");
        iRST_n = 1'b1;
        clearMon();
        for (int p = 2; p < 4; p++) begin
            iData = DATA_W'(200 + p);
            tick(1);
        end
        iLval = 1'b0;
        tick(2);
        for (int p = 0; p < 4; p++) begin
            iLval = 1'b1;
            iData = DATA_W'(300 + p);
            tick(1);
        end
        iLval = 1'b0;
        tick(2);
        iFval = 1'b0;
        tick(4);
        expFrames = 0;
        compareFrame("postreset", 0, 1'b0, 0, 0, 1'b1);

        clearMon();
        runFrame(3, 4, -1, 0, -1, 1'b1);
        expFrames = 1;
        compareFrame("resume", 12, 1'b0, 1, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
